// File: rtl/operand_fetch.sv
// operand_fetch
//   Read-side sequencer for a byte-wide synchronous SRAM. A Start command walks
//   a contiguous address range and reads consecutive byte pairs. Each pair is
//   presented as (Op_A, Op_B) on a valid/ready handshake.
//
// Ports
//   Clk, Rst                 clock, asynchronous active-low reset
//   Start                    command strobe, sampled only in IDLE
//   Base_Addr, Pair_Count    command arguments, latched on accepted Start
//   Busy, Done               command status (Done is a one-cycle pulse)
//   Sram_Addr/En/RW          SRAM read port (RW tied to read)
//   Sram_Data                SRAM read data, valid one cycle after a read
//   Op_A, Op_B, Op_Valid     operand pair output
//   Op_Ready                 downstream accept
module operand_fetch #(
    parameter int A_WIDTH   = 15,
    parameter int D_WIDTH   = 8,
    parameter int CNT_WIDTH = 14
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [A_WIDTH-1:0]   Base_Addr,
    input  logic [CNT_WIDTH-1:0] Pair_Count,
    output logic                 Busy,
    output logic                 Done,
    output logic [A_WIDTH-1:0]   Sram_Addr,
    output logic                 Sram_En,
    output logic                 Sram_RW,
    input  logic [D_WIDTH-1:0]   Sram_Data,
    output logic [D_WIDTH-1:0]   Op_A,
    output logic [D_WIDTH-1:0]   Op_B,
    output logic                 Op_Valid,
    input  logic                 Op_Ready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        CAP_B = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [A_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0] rem_q, rem_d;
    logic [A_WIDTH-1:0]   addr_q, addr_d;
    logic [D_WIDTH-1:0]   opa_q, opa_d;
    logic [D_WIDTH-1:0]   opb_q, opb_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        addr_d  = addr_q;   // address holds when the SRAM is idle
        opa_d   = opa_q;
        opb_d   = opb_q;
        Sram_En = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    ptr_d   = Base_Addr;
                    rem_d   = Pair_Count;
                    state_d = (Pair_Count == '0) ? DONE : RD_A;
                end
            end
            RD_A: begin
                Sram_En = 1'b1;
                addr_d  = ptr_q;
                state_d = RD_B;
            end
            RD_B: begin
                Sram_En = 1'b1;
                addr_d  = ptr_q + A_WIDTH'(1);
                opa_d   = Sram_Data;           // Mem[ptr] from the RD_A read
                state_d = CAP_B;
            end
            CAP_B: begin
                opb_d   = Sram_Data;           // Mem[ptr+1] from the RD_B read
                ptr_d   = ptr_q + A_WIDTH'(2);
                rem_d   = rem_q - CNT_WIDTH'(1);
                state_d = OUT;
            end
            OUT: begin
                if (Op_Ready) state_d = (rem_q == '0) ? DONE : RD_A;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    // Address is presented combinationally so RD_A drives ptr in the same cycle.
    assign Sram_Addr = addr_d;
    assign Sram_RW   = 1'b0;
    assign Op_A      = opa_q;
    assign Op_B      = opb_q;
    assign Op_Valid  = (state_q == OUT);
    assign Done      = (state_q == DONE);
    assign Busy      = (state_q == RD_A) || (state_q == RD_B) ||
                       (state_q == CAP_B) || (state_q == OUT);

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch
//   Directed bench for operand_fetch with a behavioural 1-cycle SRAM that
//   returns zero on cycles not preceded by a read.
module tb_operand_fetch;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [14:0] Base_Addr;
    logic [13:0] Pair_Count;
    logic        Busy, Done, Sram_En, Sram_RW, Op_Valid;
    logic [14:0] Sram_Addr;
    logic [7:0]  Sram_Data, Op_A, Op_B;
    logic        Op_Ready;

    logic [7:0] mem [0:32767];
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    operand_fetch dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Base_Addr(Base_Addr),
        .Pair_Count(Pair_Count), .Busy(Busy), .Done(Done),
        .Sram_Addr(Sram_Addr), .Sram_En(Sram_En), .Sram_RW(Sram_RW),
        .Sram_Data(Sram_Data), .Op_A(Op_A), .Op_B(Op_B),
        .Op_Valid(Op_Valid), .Op_Ready(Op_Ready)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (Sram_En && !Sram_RW) Sram_Data <= mem[Sram_Addr];
        else                     Sram_Data <= 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Entered with the DUT in RD_A; returns just after the transfer edge.
    task automatic pair(input logic [14:0] a0, input logic [7:0] ea, input logic [7:0] eb,
                        input int stall, input bit poke);
        logic [14:0] a1;
        a1 = a0 + 15'd1;
        chk("rda_en", Sram_En, 1);
        chk("rda_addr", Sram_Addr, a0);
        chk("rda_busy", Busy, 1);
        step();
        chk("rdb_en", Sram_En, 1);
        chk("rdb_addr", Sram_Addr, a1);
        if (poke) begin
            Start = 1'b1; Base_Addr = 15'h0040; Pair_Count = 14'd3;
        end
        step();
        Start = 1'b0;
        chk("capb_en", Sram_En, 0);
        chk("capb_addr", Sram_Addr, a1);
        chk("capb_valid", Op_Valid, 0);
        Op_Ready = (stall == 0);
        step();
        chk("out_valid", Op_Valid, 1);
        chk("out_a", Op_A, ea);
        chk("out_b", Op_B, eb);
        chk("out_en", Sram_En, 0);
        for (int i = 0; i < stall - 1; i++) begin
            step();
            chk("stall_valid", Op_Valid, 1);
            chk("stall_a", Op_A, ea);
            chk("stall_b", Op_B, eb);
            chk("stall_en", Sram_En, 0);
        end
        Op_Ready = 1'b1;
        step();
        chk("post_xfer_valid", Op_Valid, 0);
    endtask

    task automatic finish_cmd();
        chk("done_pulse", Done, 1);
        chk("done_busy", Busy, 0);
        step();
        chk("done_clear", Done, 0);
        chk("idle_busy", Busy, 0);
    endtask

    // Two-pair command over Mem[0x10..0x13]; stall applies to the first pair.
    task automatic cmd_two_pairs(input int stall, input bit poke);
        Start = 1'b1; Base_Addr = 15'h0010; Pair_Count = 14'd2;
        step();
        Start = 1'b0;
        pair(15'h0010, 8'h11, 8'h22, stall, poke);
        pair(15'h0012, 8'h33, 8'h44, 0, 1'b0);
        finish_cmd();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
        mem[15'h0010] = 8'h11; mem[15'h0011] = 8'h22;
        mem[15'h0012] = 8'h33; mem[15'h0013] = 8'h44;
        mem[15'h0040] = 8'hE1; mem[15'h0041] = 8'hE2;
        mem[15'h7FFF] = 8'hAA; mem[15'h0000] = 8'h55;
        Rst = 1'b0; Start = 1'b0; Base_Addr = '0; Pair_Count = '0; Op_Ready = 1'b1;

        // reset state
        #3;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_en", Sram_En, 0);
        chk("rst_rw", Sram_RW, 0);
        chk("rst_addr", Sram_Addr, 0);
        chk("rst_valid", Op_Valid, 0);
        chk("rst_a", Op_A, 0);
        chk("rst_b", Op_B, 0);
        step(); step();
        Rst = 1'b1;
        step();

        // 1: basic two-pair fetch
        cmd_two_pairs(0, 1'b0);

        // 2: address wrap
        Start = 1'b1; Base_Addr = 15'h7FFF; Pair_Count = 14'd1;
        step();
        Start = 1'b0;
        pair(15'h7FFF, 8'hAA, 8'h55, 0, 1'b0);
        finish_cmd();

        // 3: zero count
        Start = 1'b1; Base_Addr = 15'h0010; Pair_Count = 14'd0;
        step();
        Start = 1'b0;
        chk("zero_en", Sram_En, 0);
        chk("zero_valid", Op_Valid, 0);
        finish_cmd();
        chk("zero_after_en", Sram_En, 0);

        // 4: downstream stall of 5 cycles on the first pair
        cmd_two_pairs(5, 1'b0);

        // 5: Start during RD_B is ignored
        cmd_two_pairs(0, 1'b1);
        chk("no_requeue_en", Sram_En, 0);
        step();
        chk("no_requeue_busy", Busy, 0);

        // 6: asynchronous reset mid-RD_B
        Start = 1'b1; Base_Addr = 15'h0010; Pair_Count = 14'd2;
        step();
        Start = 1'b0;
        step();
        chk("pre_rst_rdb_en", Sram_En, 1);
        #2 Rst = 1'b0;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_en", Sram_En, 0);
        chk("arst_addr", Sram_Addr, 0);
        chk("arst_valid", Op_Valid, 0);
        chk("arst_a", Op_A, 0);
        chk("arst_done", Done, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("arst_hold_done", Done, 0);
        end
        Rst = 1'b1;
        step();
        chk("post_rst_done", Done, 0);
        Start = 1'b1; Base_Addr = 15'h0010; Pair_Count = 14'd1;
        step();
        Start = 1'b0;
        pair(15'h0010, 8'h11, 8'h22, 0, 1'b0);
        finish_cmd();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
Read-side sequencer placed directly in front of the byte-wide operand SRAM (15-bit address, 8-bit data, synchronous 1-cycle read, read data zeroed on non-read cycles). On a Start command it walks a contiguous address range and reads consecutive byte pairs as (A, B) operands. It presents each pair downstream on a valid/ready handshake. It owns the SRAM read port and never writes to it.

Parameters:
A_WIDTH, 15, SRAM address width; address arithmetic wraps modulo 2**A_WIDTH.
D_WIDTH, 8, SRAM and operand data width.
CNT_WIDTH, 14, width of the pair counter.

Ports:
Clk  in  1  rising-edge clock.
Rst  in  1  asynchronous, active-low reset.
Start  in  1  command strobe; sampled only in IDLE.
Base_Addr  in  A_WIDTH  address of the first A operand; latched on accepted Start.
Pair_Count  in  CNT_WIDTH  number of pairs to fetch; latched on accepted Start.
Busy  out  1  high from the cycle after Start is accepted through the final OUT handshake.
Done  out  1  one-cycle pulse after the last pair transfers, or after a zero-count command.
Sram_Addr  out  A_WIDTH  SRAM address.
Sram_En  out  1  SRAM enable.
Sram_RW  out  1  SRAM read/write select; tied 0 (read).
Sram_Data  in  D_WIDTH  SRAM read data (SRAM Data_Out).
Op_A  out  D_WIDTH  operand A = Mem[p].
Op_B  out  D_WIDTH  operand B = Mem[p+1].
Op_Valid  out  1  pair valid.
Op_Ready  in  1  downstream accept.

Behaviour:
- Reset (Rst=0, asynchronous): state goes to IDLE. Every output is 0: Busy, Done, Sram_En, Sram_Addr, Op_A, Op_B and Op_Valid. The pointer and remaining count are cleared. Reset asserted mid-fetch abandons the command with no Done pulse.
- States: IDLE, RD_A, RD_B, CAP_B, OUT, DONE.
- IDLE:
  - Start=1 latches ptr=Base_Addr and rem=Pair_Count.
  - rem==0 goes to DONE; otherwise goes to RD_A.
  - Start in any other state is ignored; no queueing.
- RD_A: Sram_En=1, Sram_Addr=ptr. Next state is RD_B.
- RD_B:
  - Sram_En=1, Sram_Addr=ptr+1 (mod 2**A_WIDTH).
  - Sram_Data holds Mem[ptr]; it is captured into Op_A at the end of this cycle.
  - Next state is CAP_B.
- CAP_B:
  - Sram_En=0, Sram_Addr holds its previous value.
  - Sram_Data holds Mem[ptr+1]; it is captured into Op_B at the end of this cycle.
  - ptr advances by 2 (mod 2**A_WIDTH); rem decrements by 1.
  - Next state is OUT.
- OUT:
  - Op_Valid=1; Op_A and Op_B are held stable until the handshake.
  - Transfer occurs on the rising edge where Op_Valid&&Op_Ready.
  - After transfer: rem!=0 goes to RD_A, rem==0 goes to DONE.
  - Op_Valid drops the cycle after transfer.
- DONE: Done=1 and Busy=0 for exactly one cycle, then IDLE.
- Capture timing is exact. The SRAM returns 0 on any cycle not preceded by a read, so data is sampled only in RD_B and CAP_B.
- Op_A and Op_B keep their last values after transfer. They are undefined to downstream while Op_Valid=0.
- Latency: Start accepted at edge 0 gives RD_A in cycle 1 and first Op_Valid in cycle 4. Minimum pair period is 4 cycles; each cycle Op_Ready is low adds one.
- Addresses wrap: with ptr=2**A_WIDTH-1, B is read from address 0.
- Sram_RW is 0 at all times, including reset.

Test Plan:
1. Preload Mem[0x0010..0x0013]=0x11,0x22,0x33,0x44. Start with Base_Addr=0x0010, Pair_Count=2, Op_Ready=1 -> pairs (0x11,0x22) then (0x33,0x44); first Op_Valid 4 cycles after Start; Done one-cycle pulse after second transfer; Busy then low.
2. Base_Addr=0x7FFF, Pair_Count=1, Mem[0x7FFF]=0xAA, Mem[0]=0x55 -> Op_A=0xAA, Op_B=0x55; Sram_Addr sequence 0x7FFF, 0x0000.
3. Pair_Count=0 -> no Sram_En cycles, no Op_Valid; Done pulse one cycle after Start.
4. Test 1 with Op_Ready held low for 5 cycles in OUT -> Op_Valid, Op_A and Op_B stable throughout; Sram_En=0 throughout; transfer on first Op_Ready=1 edge.
5. Second Start pulse during RD_B with a different Base_Addr -> ignored; output matches test 1 exactly.
6. Rst=0 asserted asynchronously mid-RD_B -> all outputs 0 immediately, no Done pulse. After release, a new Start of Base_Addr=0x0010, Pair_Count=1 yields (0x11,0x22).
